// File: rtl/cronometro_regresivo.sv
// BCD hh:mm:ss countdown timer with load/start/stop/ack control.
// Raises cronofin on expiry and holds it until acknowledged.
module cronometro_regresivo #(
   parameter int TICK_CYCLES = 100000000,
   parameter int TICK_W      = 27
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] hh_in,
   input  logic [7:0] mm_in,
   input  logic [7:0] ss_in,
   input  logic       start,
   input  logic       stop,
   input  logic       ack,
   output logic [7:0] hh,
   output logic [7:0] mm,
   output logic [7:0] ss,
   output logic       running,
   output logic       cronofin
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   state_t            state_q;
   logic [7:0]        hh_q, mm_q, ss_q;
   logic [7:0]        hh_d, mm_d, ss_d;
   logic [TICK_W-1:0] tick_q;
   logic              tick_last;
   logic              count_zero;
   logic              dec_zero;

   function automatic logic [7:0] clamp_60(input logic [7:0] v);
      if (v[7:4] > 4'd5 || v[3:0] > 4'd9) return 8'h59;
      return v;
   endfunction

   // A tens digit above 2 always makes the value exceed 8'h23.
   function automatic logic [7:0] clamp_24(input logic [7:0] v);
      if (v[3:0] > 4'd9 || v > 8'h23) return 8'h23;
      return v;
   endfunction

   function automatic logic [7:0] dec_60(input logic [7:0] v);
      if (v[3:0] != 4'd0) return {v[7:4], v[3:0] - 4'd1};
      if (v[7:4] != 4'd0) return {v[7:4] - 4'd1, 4'd9};
      return 8'h59;
   endfunction

   always_comb begin
      ss_d = dec_60(ss_q);
      mm_d = (ss_q == 8'h00) ? dec_60(mm_q) : mm_q;
      hh_d = (ss_q == 8'h00 && mm_q == 8'h00) ? dec_60(hh_q) : hh_q;
   end

   assign tick_last  = (tick_q == TICK_W'(TICK_CYCLES - 1));
   assign count_zero = ({hh_q, mm_q, ss_q} == 24'h000000);
   assign dec_zero   = ({hh_d, mm_d, ss_d} == 24'h000000);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         hh_q    <= 8'h00;
         mm_q    <= 8'h00;
         ss_q    <= 8'h00;
         tick_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ack) begin
                  state_q <= IDLE;
               end else if (load) begin
                  hh_q <= clamp_24(hh_in);
                  mm_q <= clamp_60(mm_in);
                  ss_q <= clamp_60(ss_in);
               end else if (start && !count_zero) begin
                  state_q <= RUN;
                  tick_q  <= '0;
               end
            end
            RUN: begin
               // load is ignored here, so it does not mask stop or the tick.
               if (ack) begin
                  state_q <= IDLE;
                  tick_q  <= '0;
               end else if (stop) begin
                  state_q <= PAUSE;
               end else if (tick_last) begin
                  tick_q <= '0;
                  hh_q   <= hh_d;
                  mm_q   <= mm_d;
                  ss_q   <= ss_d;
                  if (dec_zero) state_q <= DONE;
               end else begin
                  tick_q <= tick_q + TICK_W'(1);
               end
            end
            PAUSE: begin
               if (ack) begin
                  state_q <= IDLE;
                  tick_q  <= '0;
               end else if (load) begin
                  hh_q   <= clamp_24(hh_in);
                  mm_q   <= clamp_60(mm_in);
                  ss_q   <= clamp_60(ss_in);
                  tick_q <= '0;
               end else if (start && !count_zero) begin
                  state_q <= RUN;
               end
            end
            DONE: begin
               if (ack) begin
                  state_q <= IDLE;
               end else if (load) begin
                  state_q <= IDLE;
                  hh_q    <= clamp_24(hh_in);
                  mm_q    <= clamp_60(mm_in);
                  ss_q    <= clamp_60(ss_in);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign hh       = hh_q;
   assign mm       = mm_q;
   assign ss       = ss_q;
   assign running  = (state_q == RUN);
   assign cronofin = (state_q == DONE);

endmodule

// File: tb/tb_cronometro_regresivo.sv
// Bench for cronometro_regresivo: directed scenarios plus random command traffic
// checked against a reference that tracks the remaining time as plain seconds.
module tb_cronometro_regresivo;

   localparam int TC = 4;

   logic       clk = 1'b0;
   logic       rst, load, start, stop, ack;
   logic [7:0] hh_in, mm_in, ss_in;
   logic [7:0] hh, mm, ss;
   logic       running, cronofin;
   logic [25:0] obs;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference: mode 0=idle 1=run 2=pause 3=done, remaining time in seconds.
   int m_secs = 0;
   int m_mode = 0;
   int m_tick = 0;

   cronometro_regresivo #(.TICK_CYCLES(TC), .TICK_W(3)) dut (
      .clk(clk), .rst(rst), .load(load), .hh_in(hh_in), .mm_in(mm_in), .ss_in(ss_in),
      .start(start), .stop(stop), .ack(ack), .hh(hh), .mm(mm), .ss(ss),
      .running(running), .cronofin(cronofin)
   );

   always #5 clk = ~clk;

   assign obs = {hh, mm, ss, running, cronofin};

   function automatic int sec_field(input logic [7:0] v);
      int t, u;
      t = int'(v[7:4]);
      u = int'(v[3:0]);
      if (t > 5 || u > 9) return 59;
      return t * 10 + u;
   endfunction

   function automatic int hour_field(input logic [7:0] v);
      int t, u;
      t = int'(v[7:4]);
      u = int'(v[3:0]);
      if (u > 9 || t > 9 || t * 10 + u > 23) return 23;
      return t * 10 + u;
   endfunction

   function automatic logic [7:0] to_bcd(input int v);
      logic [7:0] r;
      r[7:4] = 4'(v / 10);
      r[3:0] = 4'(v % 10);
      return r;
   endfunction

   function automatic logic [25:0] expv();
      return {to_bcd(m_secs / 3600), to_bcd((m_secs / 60) % 60), to_bcd(m_secs % 60),
              m_mode == 1, m_mode == 3};
   endfunction

   function automatic int preset_secs();
      return hour_field(hh_in) * 3600 + sec_field(mm_in) * 60 + sec_field(ss_in);
   endfunction

   task automatic model_update();
      if (!rst) begin
         m_secs = 0; m_mode = 0; m_tick = 0;
      end else begin
         case (m_mode)
            0: if (ack) ;
               else if (load) m_secs = preset_secs();
               else if (start && m_secs != 0) begin m_mode = 1; m_tick = 0; end
            1: if (ack) begin m_mode = 0; m_tick = 0; end
               else if (stop) m_mode = 2;
               else if (m_tick == TC - 1) begin
                  m_tick = 0;
                  m_secs = m_secs - 1;
                  if (m_secs == 0) m_mode = 3;
               end else m_tick = m_tick + 1;
            2: if (ack) begin m_mode = 0; m_tick = 0; end
               else if (load) begin m_secs = preset_secs(); m_tick = 0; end
               else if (start && m_secs != 0) m_mode = 1;
            default: if (ack) m_mode = 0;
               else if (load) begin m_secs = preset_secs(); m_mode = 0; end
         endcase
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      hh_in = h; mm_in = m; ss_in = s; load = 1'b1;
      step();
      load = 1'b0;
   endtask

   task automatic do_pulse(input logic st, input logic sp, input logic a);
      start = st; stop = sp; ack = a;
      step();
      start = 1'b0; stop = 1'b0; ack = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         load = 1'b1; start = 1'b1; stop = 1'($urandom); ack = 1'b0;
         hh_in = 8'($urandom); mm_in = 8'($urandom); ss_in = 8'($urandom);
         step();
         n_cmp++;
         if (obs !== 26'h0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h required %h", obs, 26'h0);
         end
      end
      rst = 1'b1; load = 1'b0; start = 1'b0; stop = 1'b0; ack = 1'b0;
      step();
      n_cmp++;
      if (obs !== expv() || obs !== 26'h0) begin
         n_fail++;
         $display("FAIL reset_release: got %h required %h", obs, expv());
      end
   endtask

   task automatic test_basic();
      do_load(8'h00, 8'h00, 8'h03);
      do_pulse(1'b1, 1'b0, 1'b0);
      for (int c = 1; c <= 34; c++) begin
         step();
         n_cmp++;
         if (obs !== expv()) begin
            n_fail++;
            $display("FAIL basic_model c=%0d: got %h required %h", c, obs, expv());
         end
         if (c == 4 || c == 8 || c == 12) begin
            n_cmp++;
            if (ss !== to_bcd(3 - c / 4)) begin
               n_fail++;
               $display("FAIL basic_ss c=%0d: got %h required %h", c, ss, to_bcd(3 - c / 4));
            end
         end
         if (c >= 12) begin
            n_cmp++;
            if (cronofin !== 1'b1 || running !== 1'b0) begin
               n_fail++;
               $display("FAIL basic_done c=%0d: got fin=%b run=%b required fin=1 run=0",
                        c, cronofin, running);
            end
         end
      end
      do_pulse(1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (cronofin !== 1'b0 || running !== 1'b0 || obs !== expv()) begin
         n_fail++;
         $display("FAIL basic_ack: got %h required %h", obs, expv());
      end
   endtask

   task automatic test_borrow();
      do_load(8'h01, 8'h00, 8'h00);
      do_pulse(1'b1, 1'b0, 1'b0);
      for (int c = 1; c <= 8; c++) begin
         step();
         n_cmp++;
         if (obs !== expv()) begin
            n_fail++;
            $display("FAIL borrow_model c=%0d: got %h required %h", c, obs, expv());
         end
      end
      n_cmp++;
      if ({hh, mm, ss} !== 24'h005958) begin
         n_fail++;
         $display("FAIL borrow_value: got %h required %h", {hh, mm, ss}, 24'h005958);
      end
      do_pulse(1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_pause();
      do_load(8'h00, 8'h00, 8'h05);
      do_pulse(1'b1, 1'b0, 1'b0);
      step();
      step();
      do_pulse(1'b0, 1'b1, 1'b0);
      for (int c = 0; c < 10; c++) begin
         step();
         n_cmp++;
         if (ss !== 8'h05 || running !== 1'b0 || obs !== expv()) begin
            n_fail++;
            $display("FAIL pause_hold c=%0d: got %h required %h", c, obs, expv());
         end
      end
      do_pulse(1'b1, 1'b0, 1'b0);
      step();
      n_cmp++;
      if (ss !== 8'h05 || running !== 1'b1) begin
         n_fail++;
         $display("FAIL resume_early: got ss=%h run=%b required ss=05 run=1", ss, running);
      end
      step();
      n_cmp++;
      if (ss !== 8'h04 || obs !== expv()) begin
         n_fail++;
         $display("FAIL resume_tick: got %h required %h", obs, expv());
      end
      do_pulse(1'b1, 1'b1, 1'b0);
      n_cmp++;
      if (running !== 1'b0 || cronofin !== 1'b0 || obs !== expv()) begin
         n_fail++;
         $display("FAIL start_stop_run: got %h required %h", obs, expv());
      end
      do_pulse(1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_ignored();
      do_load(8'h00, 8'h00, 8'h00);
      do_pulse(1'b1, 1'b0, 1'b0);
      step();
      n_cmp++;
      if (obs !== 26'h0 || obs !== expv()) begin
         n_fail++;
         $display("FAIL start_zero: got %h required %h", obs, 26'h0);
      end
      do_load(8'h7A, 8'h99, 8'h99);
      n_cmp++;
      if ({hh, mm, ss} !== 24'h235959) begin
         n_fail++;
         $display("FAIL clamp: got %h required %h", {hh, mm, ss}, 24'h235959);
      end
      do_pulse(1'b1, 1'b0, 1'b0);
      step();
      do_load(8'h00, 8'h00, 8'h01);
      n_cmp++;
      if ({hh, mm, ss} !== 24'h235959 || running !== 1'b1) begin
         n_fail++;
         $display("FAIL load_in_run: got %h run=%b required 235959 run=1", {hh, mm, ss}, running);
      end
      step();
      step();
      n_cmp++;
      if ({hh, mm, ss} !== 24'h235958 || obs !== expv()) begin
         n_fail++;
         $display("FAIL run_after_load: got %h required %h", obs, expv());
      end
      do_pulse(1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_reset_mid();
      do_load(8'h00, 8'h00, 8'h02);
      do_pulse(1'b1, 1'b0, 1'b0);
      step();
      rst = 1'b0;
      step();
      rst = 1'b1;
      n_cmp++;
      if (obs !== 26'h0) begin
         n_fail++;
         $display("FAIL reset_in_run: got %h required %h", obs, 26'h0);
      end
      do_load(8'h00, 8'h00, 8'h01);
      do_pulse(1'b1, 1'b0, 1'b0);
      for (int c = 0; c < 5; c++) step();
      n_cmp++;
      if (cronofin !== 1'b1) begin
         n_fail++;
         $display("FAIL done_before_reset: got fin=%b required 1", cronofin);
      end
      rst = 1'b0;
      step();
      rst = 1'b1;
      n_cmp++;
      if (cronofin !== 1'b0 || obs !== expv()) begin
         n_fail++;
         $display("FAIL reset_in_done: got %h required %h", obs, expv());
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 1500; c++) begin
         rst   = ($urandom_range(0, 299) != 0);
         load  = ($urandom_range(0, 19) == 0);
         start = ($urandom_range(0, 3) == 0);
         stop  = ($urandom_range(0, 11) == 0);
         ack   = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 3) == 0) begin
            hh_in = 8'($urandom); mm_in = 8'($urandom); ss_in = 8'($urandom);
         end else begin
            hh_in = 8'h00;
            mm_in = ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00;
            ss_in = to_bcd($urandom_range(0, 9));
         end
         step();
         n_cmp++;
         if (obs !== expv()) begin
            n_fail++;
            $display("FAIL random c=%0d: got %h required %h", c, obs, expv());
         end
      end
      rst = 1'b1; load = 1'b0; start = 1'b0; stop = 1'b0; ack = 1'b0;
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; start = 1'b0; stop = 1'b0; ack = 1'b0;
      hh_in = 8'h00; mm_in = 8'h00; ss_in = 8'h00;
      #2;
      test_reset();
      test_basic();
      test_borrow();
      test_pause();
      test_ignored();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/cronometro_regresivo.md
Name: cronometro_regresivo

Overview:
- BCD countdown timer (hh:mm:ss) that produces the `cronofin` level consumed by the Audio alarm block.
- The user loads a preset, then starts, pauses and resumes the count.
- On reaching 00:00:00 the block raises `cronofin` and holds it until acknowledged.
- It sits between the user-input/RTC register logic and the Audio block, and shares the system clock.

Parameters:
TICK_CYCLES, 100000000, clk cycles per one-second decrement (benches use 4)
TICK_W, 27, width of internal tick counter; must satisfy 2^TICK_W > TICK_CYCLES

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-low reset
load  in  1  one-cycle pulse; copy hh_in/mm_in/ss_in into count
hh_in  in  8  preset hours, 2-digit BCD
mm_in  in  8  preset minutes, 2-digit BCD
ss_in  in  8  preset seconds, 2-digit BCD
start  in  1  one-cycle pulse; begin or resume counting
stop  in  1  one-cycle pulse; pause counting
ack  in  1  one-cycle pulse; clear alarm, return to IDLE
hh  out  8  current hours, BCD
mm  out  8  current minutes, BCD
ss  out  8  current seconds, BCD
running  out  1  high while in RUN
cronofin  out  1  high while in DONE (timer expired)

Behaviour:
- **Reset:** rst sampled low at a clk edge sets state=IDLE, hh=mm=ss=8'h00, tick counter=0, running=0, cronofin=0. Reset overrides every other input, including mid-count and in DONE.
- **States:** IDLE, RUN, PAUSE, DONE. All outputs are registered; running and cronofin decode directly from state registers, so there are no glitches.
- **Command priority** when pulses coincide: ack > load > stop > start.
- **IDLE:**
  - load copies the presets (see clamping).
  - start with count != 0 goes to RUN and clears the tick counter.
  - start with count == 0 is ignored and the state stays IDLE.
- **RUN:**
  - The tick counter increments each cycle. When it equals TICK_CYCLES-1, it wraps to 0 and the count decrements in that same edge.
  - The first decrement therefore lands exactly TICK_CYCLES cycles after the start edge.
  - stop goes to PAUSE, freezing both the count and the tick counter. A stop coinciding with a tick edge wins: no decrement occurs.
  - load in RUN is ignored.
  - ack in RUN goes to IDLE, keeps the count and clears the tick counter.
- **PAUSE:**
  - start resumes RUN with the tick counter unchanged, so a partial second is preserved.
  - load updates the count and clears the tick counter, staying in PAUSE.
  - ack goes to IDLE.
- **Decrement (BCD, borrow chain):**
  - Seconds units 0 → 9 with a borrow to seconds tens.
  - Seconds 00 → 59 with a borrow to minutes; minutes 00 → 59 with a borrow to hours.
  - Hours never wrap, because the count reaches zero first.
- **Expiry:** a decrement whose result is 00:00:00 moves the block to DONE on the same edge. In the same edge:
  - cronofin rises;
  - running falls;
  - the outputs show 00:00:00.
- **DONE:**
  - The count stays 0 and cronofin stays high indefinitely.
  - start and stop are ignored.
  - load updates the count and goes to IDLE, dropping cronofin.
  - ack goes to IDLE and drops cronofin on the next edge.
- **Preset clamping on load:**
  - A seconds or minutes value with a tens digit > 5 or any BCD digit > 9 loads as 8'h59.
  - An hours value > 8'h23 or with a digit > 9 loads as 8'h23.
- **Width rules:** all count fields are 8-bit packed BCD {tens, units}. The tick counter is TICK_W bits and compares against TICK_CYCLES-1.

Test Plan (TICK_CYCLES=4):
1. **Reset:** rst=0 for 2 cycles with random inputs → hh/mm/ss=00, running=0, cronofin=0; load/start asserted during reset have no effect.
2. **Basic countdown:** load 00:00:03, start.
   - ss reads 02, 01, 00 at 4, 8 and 12 cycles after the start edge.
   - cronofin=1 and running=0 from cycle 12 onward and stay so for 20+ cycles.
   - ack → cronofin=0 next edge, state IDLE.
3. **Borrow chain:** load 01:00:00, start → after 4 cycles the count reads 00:59:59; after a further 4 cycles it reads 00:59:58.
4. **Pause/resume:** load 00:00:05, start, stop 2 cycles later.
   - Hold 10 cycles → ss stays 05.
   - start → ss=04 exactly 2 cycles after resume.
   - Simultaneous start+stop in RUN → PAUSE.
5. **Ignored and clamped commands:**
   - start with count 00:00:00 → stays IDLE, cronofin=0.
   - load 8'h7A/8'h99/8'h99 → 23:59:59.
   - load during RUN → count unaffected.
6. **Reset mid-operation:**
   - rst low during RUN at 00:00:02 → next edge all zero, IDLE.
   - rst low in DONE → cronofin=0 next edge.
